button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 135 +++++++++++++
 tb/tb_button_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise, debounce and strobe an active-low button bus
module button_conditioner #(
    parameter int NBTN            = 8,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 6000000,
    parameter int REPEAT_CYCLES   = 1200000
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NBTN-1:0] nbtn,
    output logic [NBTN-1:0] btn,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_repeat
);

    localparam int DW     = $clog2(DEBOUNCE_CYCLES);
    localparam int HSPAN  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW     = $clog2(HSPAN);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} hold_state_t;

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] s;

    // Synchroniser idles at 1 so that reset looks like "all released".
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= nbtn;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    for (genvar i = 0; i < NBTN; i++) begin : g_ch
        logic [DW-1:0] dcnt;
        logic          level;
        logic          due;
        logic          level_next;
        logic          press_q;
        logic          release_q;
        logic          repeat_q;
        logic          repeat_next;
        logic [HW-1:0] hcnt;
        logic [HW-1:0] hcnt_next;
        hold_state_t   state;
        hold_state_t   state_next;

        assign due        = (s[i] != level) && (dcnt == DEB_LAST);
        assign level_next = due ? s[i] : level;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                dcnt      <= '0;
                level     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= due && s[i];
                release_q <= due && !s[i];
                level     <= level_next;
                if ((s[i] == level) || due) begin
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                state    <= S_IDLE;
                hcnt     <= '0;
                repeat_q <= 1'b0;
            end else begin
                state    <= state_next;
                hcnt     <= hcnt_next;
                repeat_q <= repeat_next;
            end
        end

        // Looking at the next level lets a release on this edge override a due repeat.
        always_comb begin
            state_next  = state;
            hcnt_next   = hcnt;
            repeat_next = 1'b0;
            if (!level_next) begin
                state_next = S_IDLE;
                hcnt_next  = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state_next = S_WAIT;
                        hcnt_next  = '0;
                    end
                    S_WAIT: begin
                        if (hcnt == HOLD_LAST) begin
                            repeat_next = 1'b1;
                            hcnt_next   = '0;
                            state_next  = S_REPEAT;
                        end else begin
                            hcnt_next = hcnt + HW'(1);
                        end
                    end
                    S_REPEAT: begin
                        if (hcnt == REP_LAST) begin
                            repeat_next = 1'b1;
                            hcnt_next   = '0;
                        end else begin
                            hcnt_next = hcnt + HW'(1);
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        hcnt_next  = '0;
                    end
                endcase
            end
        end

        assign btn[i]         = level;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - table-driven bench for button_conditioner
module tb_button_conditioner;

    logic       clk;
    logic       nrst;
    logic [3:0] nbtn;
    logic [3:0] btn;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    int checks;
    int failures;

    button_conditioner #(
        .NBTN(4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .nbtn(nbtn),
        .btn(btn),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_repeat(btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each row: drive nbtn, then for n edges expect the same four output vectors.
    typedef struct {
        logic [3:0] nbtn;
        int         n;
        logic [3:0] btn;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] nb, input int n, input logic [3:0] b,
                       input logic [3:0] p, input logic [3:0] r, input logic [3:0] q);
        vec_t v;
        v.nbtn = nb; v.n = n; v.btn = b; v.press = p; v.rel = r; v.rpt = q;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int tag, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0d: got %h required %h", name, tag, act, exp);
        end
    endtask

    task automatic check_all(input int tag, input logic [3:0] b, input logic [3:0] p,
                             input logic [3:0] r, input logic [3:0] q);
        check("btn", tag, btn, b);
        check("btn_press", tag, btn_press, p);
        check("btn_release", tag, btn_release, r);
        check("btn_repeat", tag, btn_repeat, q);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Scenario 1: reset held then released with all buttons up.
        nrst = 1'b0;
        nbtn = 4'hF;
        #1;
        check_all(0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_all(k, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        nrst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_all(100 + k, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Scenario 2: clean press and release of bit 0.
        add(4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hE, 1, 4'h1, 4'h1, 4'h0, 4'h0);
        add(4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h0);
        add(4'hF, 5, 4'h1, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h0, 4'h0, 4'h1, 4'h0);
        add(4'hF, 2, 4'h0, 4'h0, 4'h0, 4'h0);
        // Scenario 5: bits 0 and 3 together.
        add(4'h6, 5, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'h6, 1, 4'h9, 4'h9, 4'h0, 4'h0);
        add(4'h6, 1, 4'h9, 4'h0, 4'h0, 4'h0);
        add(4'hF, 5, 4'h9, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h0, 4'h0, 4'h9, 4'h0);
        add(4'hF, 2, 4'h0, 4'h0, 4'h0, 4'h0);
        // Scenario 3: bit 1 bounces once before settling low.
        add(4'hD, 3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hD, 5, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hD, 1, 4'h2, 4'h2, 4'h0, 4'h0);
        add(4'hD, 1, 4'h2, 4'h0, 4'h0, 4'h0);
        add(4'hF, 5, 4'h2, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h0, 4'h0, 4'h2, 4'h0);
        add(4'hF, 2, 4'h0, 4'h0, 4'h0, 4'h0);
        // Scenario 4: bit 2 held; release lands on the edge a repeat would be due.
        add(4'hB, 5, 4'h0, 4'h0, 4'h0, 4'h0);
        add(4'hB, 1, 4'h4, 4'h4, 4'h0, 4'h0);
        add(4'hB, 7, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'hB, 1, 4'h4, 4'h0, 4'h0, 4'h4);
        add(4'hB, 2, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'hB, 1, 4'h4, 4'h0, 4'h0, 4'h4);
        add(4'hF, 2, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h4, 4'h0, 4'h0, 4'h4);
        add(4'hF, 2, 4'h4, 4'h0, 4'h0, 4'h0);
        add(4'hF, 1, 4'h0, 4'h0, 4'h4, 4'h0);
        add(4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);

        for (int r = 0; r < vecs.size(); r++) begin
            nbtn = vecs[r].nbtn;
            for (int k = 0; k < vecs[r].n; k++) begin
                step();
                check_all(1000 + r * 100 + k, vecs[r].btn, vecs[r].press,
                          vecs[r].rel, vecs[r].rpt);
            end
        end

        // Scenario 6: reset pulsed while bit 2 is held, between edges 15 and 16.
        nbtn = 4'hB;
        for (int e = 1; e <= 15; e++) begin
            step();
            if (e == 6)
                check_all(6000 + e, 4'h4, 4'h4, 4'h0, 4'h0);
            else if (e == 14)
                check_all(6000 + e, 4'h4, 4'h0, 4'h0, 4'h4);
            else if (e > 6)
                check_all(6000 + e, 4'h4, 4'h0, 4'h0, 4'h0);
            else
                check_all(6000 + e, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        #2;
        nrst = 1'b0;
        #1;
        check_all(6100, 4'h0, 4'h0, 4'h0, 4'h0);
        #3;
        nrst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6)
                check_all(6200 + e, 4'h4, 4'h4, 4'h0, 4'h0);
            else if (e == 7)
                check_all(6200 + e, 4'h4, 4'h0, 4'h0, 4'h0);
            else
                check_all(6200 + e, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
